// File: rtl/pipe_fetch_ctrl.sv
// pipe_fetch_ctrl: in-order instruction fetch front-end with a circular response buffer.
// Latency: request at t, response at t+k, presented at t+k+1 (t+k when PIPE_FETCH_RESP_BYPASS_EN is defined).
// Backpressure: next_stall holds the buffer; new requests stop once buffer + drop credits are exhausted.
//
// Ports:
//   clk, reset                       clock and synchronous active-high reset
//   sd                               security-domain tag (all other ports share this domain)
//   imemreq_val/rdy/addr             instruction-memory request channel (addr = current PC)
//   imemresp_val/data                in-order response channel, always accepted
//   redirect_val/target              squash from downstream with the new PC
//   next_stall                       stall from downstream stage
//   next_val/pc/inst                 presented instruction to downstream stage
// Optional build macro: PIPE_FETCH_RESP_BYPASS_EN (combinational response-to-output bypass).

module pipe_fetch_ctrl #(
  parameter int unsigned             p_addr_nbits   = 32,
  parameter int unsigned             p_data_nbits   = 32,
  parameter logic [p_addr_nbits-1:0] p_reset_pc     = 32'h00000200,
  parameter int unsigned             p_max_inflight = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sd,
  output logic                    imemreq_val,
  input  logic                    imemreq_rdy,
  output logic [p_addr_nbits-1:0] imemreq_addr,
  input  logic                    imemresp_val,
  input  logic [p_data_nbits-1:0] imemresp_data,
  input  logic                    redirect_val,
  input  logic [p_addr_nbits-1:0] redirect_target,
  input  logic                    next_stall,
  output logic                    next_val,
  output logic [p_addr_nbits-1:0] next_pc,
  output logic [p_data_nbits-1:0] next_inst
);

  localparam int unsigned PW = $clog2(p_max_inflight);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(p_max_inflight);

  // The domain tag carries no logic here; every port is in the same domain.
  logic unused_sd;
  assign unused_sd = sd;

  logic [p_addr_nbits-1:0]   pc_q, pc_d;
  logic [p_max_inflight-1:0] alloc_q, alloc_d;
  logic [p_max_inflight-1:0] filled_q, filled_d;
  logic [p_addr_nbits-1:0]   bpc_q   [p_max_inflight];
  logic [p_data_nbits-1:0]   binst_q [p_max_inflight];
  logic [PW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d;
  // Oldest allocated-but-unfilled entry; responses return in order so this just walks forward.
  logic [PW-1:0]             fill_ptr_q, fill_ptr_d;
  logic [CW-1:0]             occ_q, occ_d;
  logic [CW-1:0]             drop_q, drop_d;

  logic [CW-1:0] unfilled;
  logic          credit_ok;
  logic          req_fire;
  logic          resp_drop;
  logic          resp_fill;
  logic          head_alloc;
  logic          head_filled;
  logic          deq;

  always_comb begin
    unfilled = '0;
    for (int i = 0; i < int'(p_max_inflight); i++) begin
      unfilled = unfilled + CW'(alloc_q[i] && !filled_q[i]);
    end
  end

  // Credits use registered occupancy only, so a same-cycle dequeue never frees a slot early.
  assign credit_ok    = ({1'b0, occ_q} + {1'b0, drop_q}) < CREDIT_LIMIT;
  assign imemreq_val  = !reset && !redirect_val && credit_ok;
  assign imemreq_addr = pc_q;
  assign req_fire     = imemreq_val && imemreq_rdy;

  assign resp_drop   = imemresp_val && (drop_q != '0);
  assign resp_fill   = imemresp_val && (drop_q == '0) && !redirect_val;
  assign head_alloc  = alloc_q[rd_ptr_q];
  assign head_filled = filled_q[rd_ptr_q];
  assign next_pc     = bpc_q[rd_ptr_q];

`ifdef PIPE_FETCH_RESP_BYPASS_EN
  // An unfilled head is always the fill target, so a live response can be forwarded directly.
  logic head_bypass;
  assign head_bypass = resp_fill && head_alloc && !head_filled;
  assign next_val    = !reset && !redirect_val && head_alloc && (head_filled || head_bypass);
  assign next_inst   = head_filled ? binst_q[rd_ptr_q] : imemresp_data;
`else
  assign next_val    = !reset && !redirect_val && head_alloc && head_filled;
  assign next_inst   = binst_q[rd_ptr_q];
`endif

  assign deq = next_val && !next_stall;

  always_comb begin
    pc_d       = pc_q;
    alloc_d    = alloc_q;
    filled_d   = filled_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fill_ptr_d = fill_ptr_q;
    occ_d      = occ_q;
    drop_d     = drop_q;
    if (redirect_val) begin
      // Every unfilled entry still has a response coming; those become drops.
      // The response landing this cycle is consumed here, hence the subtraction.
      pc_d       = redirect_target;
      alloc_d    = '0;
      filled_d   = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fill_ptr_d = '0;
      occ_d      = '0;
      drop_d     = drop_q + unfilled - CW'(imemresp_val);
    end else begin
      if (req_fire) begin
        alloc_d[wr_ptr_q]  = 1'b1;
        filled_d[wr_ptr_q] = 1'b0;
        wr_ptr_d           = wr_ptr_q + PW'(1);
        pc_d               = pc_q + p_addr_nbits'(4);
      end
      if (resp_drop) begin
        drop_d = drop_q - CW'(1);
      end
      if (resp_fill) begin
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d           = fill_ptr_q + PW'(1);
      end
      // Applied last so a bypassed head leaves without remaining marked filled.
      if (deq) begin
        alloc_d[rd_ptr_q]  = 1'b0;
        filled_d[rd_ptr_q] = 1'b0;
        rd_ptr_d           = rd_ptr_q + PW'(1);
      end
      occ_d = occ_q + CW'(req_fire) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= p_reset_pc;
      alloc_q    <= '0;
      filled_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      occ_q      <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      alloc_q    <= alloc_d;
      filled_q   <= filled_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_ptr_q <= fill_ptr_d;
      occ_q      <= occ_d;
      drop_q     <= drop_d;
    end
  end

  // Payload storage needs no reset; validity lives in alloc/filled.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      bpc_q[wr_ptr_q] <= pc_q;
    end
    if (resp_fill) begin
      binst_q[fill_ptr_q] <= imemresp_data;
    end
  end

  // A response must always match an outstanding request or a pending drop.
  assert property (@(posedge clk) disable iff (reset)
    imemresp_val |-> ((drop_q != '0) || (unfilled != '0)));

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
module tb_pipe_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        sd;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_data;
  logic        redirect_val;
  logic [31:0] redirect_target;
  logic        next_stall;
  logic        next_val;
  logic [31:0] next_pc;
  logic [31:0] next_inst;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int lat    = 1;

  logic [31:0] rq_addr[$];
  int          rq_due[$];
  logic [31:0] pres[$];

  always #5 clk = ~clk;

  pipe_fetch_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .sd              (sd),
    .imemreq_val     (imemreq_val),
    .imemreq_rdy     (imemreq_rdy),
    .imemreq_addr    (imemreq_addr),
    .imemresp_val    (imemresp_val),
    .imemresp_data   (imemresp_data),
    .redirect_val    (redirect_val),
    .redirect_target (redirect_target),
    .next_stall      (next_stall),
    .next_val        (next_val),
    .next_pc         (next_pc),
    .next_inst       (next_inst)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: record this cycle's handshakes, then move to just after the next posedge
  // and drive the memory response due in the new cycle.
  task automatic adv();
    if (!reset && imemreq_val && imemreq_rdy) begin
      rq_addr.push_back(imemreq_addr);
      rq_due.push_back(cyc + lat);
    end
    if (!reset && next_val && !next_stall) begin
      pres.push_back(next_pc);
      chk("deq_inst", next_inst, inst_of(next_pc));
    end
    @(posedge clk);
    #1;
    cyc++;
    imemresp_val  = 1'b0;
    imemresp_data = 32'h0;
    if (rq_due.size() > 0 && rq_due[0] == cyc) begin
      imemresp_val  = 1'b1;
      imemresp_data = inst_of(rq_addr[0]);
      void'(rq_addr.pop_front());
      void'(rq_due.pop_front());
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      adv();
    end
  endtask

  task automatic do_reset(input int l);
    reset           = 1'b1;
    sd              = 1'b0;
    redirect_val    = 1'b0;
    redirect_target = 32'h0;
    next_stall      = 1'b0;
    imemreq_rdy     = 1'b1;
    imemresp_val    = 1'b0;
    imemresp_data   = 32'h0;
    rq_addr.delete();
    rq_due.delete();
    pres.delete();
    lat = l;
    @(negedge clk);
    chk("rst_req_val", imemreq_val, 0);
    chk("rst_next_val", next_val, 0);
    adv();
    @(negedge clk);
    adv();
    reset = 1'b0;
    cyc   = 1;
  endtask

  initial begin
    int n400;

    // 1-cycle memory, no stall.
    do_reset(1);
    @(negedge clk);
    chk("t1_c1_val", imemreq_val, 1);
    chk("t1_c1_addr", imemreq_addr, 32'h200);
    chk("t1_c1_nval", next_val, 0);
    adv();
    @(negedge clk);
    chk("t1_c2_val", imemreq_val, 1);
    chk("t1_c2_addr", imemreq_addr, 32'h204);
`ifdef PIPE_FETCH_RESP_BYPASS_EN
    chk("t1_c2_nval", next_val, 1);
    chk("t1_c2_npc", next_pc, 32'h200);
`else
    chk("t1_c2_nval", next_val, 0);
`endif
    adv();
    @(negedge clk);
`ifdef PIPE_FETCH_RESP_BYPASS_EN
    chk("t1_c3_val", imemreq_val, 1);
    chk("t1_c3_addr", imemreq_addr, 32'h208);
    chk("t1_c3_npc", next_pc, 32'h204);
`else
    chk("t1_c3_val", imemreq_val, 0);
    chk("t1_c3_npc", next_pc, 32'h200);
`endif
    chk("t1_c3_nval", next_val, 1);
    adv();
    @(negedge clk);
`ifdef PIPE_FETCH_RESP_BYPASS_EN
    chk("t1_c4_addr", imemreq_addr, 32'h20C);
    chk("t1_c4_npc", next_pc, 32'h208);
`else
    chk("t1_c4_addr", imemreq_addr, 32'h208);
    chk("t1_c4_npc", next_pc, 32'h204);
`endif
    chk("t1_c4_nval", next_val, 1);
    adv();
    step(6);
    chk("t1_pres0", pres[0], 32'h200);
    chk("t1_pres1", pres[1], 32'h204);
    chk("t1_pres2", pres[2], 32'h208);

    // Memory not ready for 5 cycles (also a reset from mid-operation).
    do_reset(1);
    imemreq_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_val", imemreq_val, 1);
      chk("t2_addr", imemreq_addr, 32'h200);
      chk("t2_nval", next_val, 0);
      adv();
    end
    imemreq_rdy = 1'b1;
    @(negedge clk);
    chk("t2_resume_addr", imemreq_addr, 32'h200);
    adv();
    @(negedge clk);
    chk("t2_next_addr", imemreq_addr, 32'h204);
    adv();

    // Downstream stall held: credits run out after two requests.
    do_reset(1);
    next_stall = 1'b1;
    @(negedge clk);
    chk("t3_c1_addr", imemreq_addr, 32'h200);
    adv();
    @(negedge clk);
    chk("t3_c2_val", imemreq_val, 1);
    chk("t3_c2_addr", imemreq_addr, 32'h204);
    adv();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_blocked_val", imemreq_val, 0);
      adv();
    end
    next_stall = 1'b0;
    @(negedge clk);
    chk("t3_c6_nval", next_val, 1);
    chk("t3_c6_npc", next_pc, 32'h200);
    chk("t3_c6_val", imemreq_val, 0);
    adv();
    @(negedge clk);
    chk("t3_c7_nval", next_val, 1);
    chk("t3_c7_npc", next_pc, 32'h204);
    chk("t3_c7_val", imemreq_val, 1);
    chk("t3_c7_addr", imemreq_addr, 32'h208);
    adv();

    // 3-cycle memory, redirect with two requests outstanding.
    do_reset(3);
    step(2);
    redirect_val    = 1'b1;
    redirect_target = 32'h400;
    @(negedge clk);
    chk("t4_c3_val", imemreq_val, 0);
    chk("t4_c3_nval", next_val, 0);
    adv();
    redirect_val = 1'b0;
    @(negedge clk);
    chk("t4_c4_drop", 32'(dut.drop_q), 2);
    chk("t4_c4_val", imemreq_val, 0);
    adv();
    @(negedge clk);
    chk("t4_c5_drop", 32'(dut.drop_q), 1);
    chk("t4_c5_val", imemreq_val, 1);
    chk("t4_c5_addr", imemreq_addr, 32'h400);
    adv();
    @(negedge clk);
    chk("t4_c6_drop", 32'(dut.drop_q), 0);
    chk("t4_c6_addr", imemreq_addr, 32'h404);
    adv();
    step(8);
    chk("t4_pres0", pres[0], 32'h400);
    chk("t4_pres1", pres[1], 32'h404);

    // Redirect in the cycle a response lands, one more still outstanding.
    do_reset(3);
    step(3);
    redirect_val    = 1'b1;
    redirect_target = 32'h400;
    @(negedge clk);
    chk("t5_c4_val", imemreq_val, 0);
    chk("t5_c4_nval", next_val, 0);
    adv();
    redirect_val = 1'b0;
    @(negedge clk);
    chk("t5_c5_drop", 32'(dut.drop_q), 1);
    chk("t5_c5_addr", imemreq_addr, 32'h400);
    chk("t5_c5_val", imemreq_val, 1);
    adv();
    @(negedge clk);
    chk("t5_c6_drop", 32'(dut.drop_q), 0);
    adv();
    step(8);
    chk("t5_pres0", pres[0], 32'h400);

    // Back-to-back redirects with two in flight.
    do_reset(3);
    step(2);
    redirect_val    = 1'b1;
    redirect_target = 32'h400;
    @(negedge clk);
    adv();
    redirect_target = 32'h800;
    @(negedge clk);
    chk("t6_c4_drop", 32'(dut.drop_q), 2);
    chk("t6_c4_nval", next_val, 0);
    adv();
    redirect_val = 1'b0;
    @(negedge clk);
    chk("t6_c5_drop", 32'(dut.drop_q), 1);
    chk("t6_c5_addr", imemreq_addr, 32'h800);
    adv();
    @(negedge clk);
    chk("t6_c6_drop", 32'(dut.drop_q), 0);
    adv();
    step(8);
    chk("t6_pres0", pres[0], 32'h800);
    chk("t6_pres1", pres[1], 32'h804);
    n400 = 0;
    foreach (pres[i]) if (pres[i] == 32'h400) n400++;
    chk("t6_no_400", 32'(n400), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_fetch_ctrl.md
Name: pipe_fetch_ctrl

Overview:
- Fetch front-end that sits directly upstream of the first pipeline stage's valid/stall/squash controller.
- Holds the PC and issues in-order instruction-memory requests.
- Buffers responses together with their PCs and presents {pc, inst} plus a valid bit to the downstream stage.
- Handles redirects (squash) by flushing buffered entries and dropping in-flight responses.

Parameters:
p_addr_nbits, 32, PC / request address width
p_data_nbits, 32, instruction width
p_reset_pc, 32'h00000200, PC value after reset
p_max_inflight, 2, fetch buffer depth and outstanding-request credit limit (power of two, >= 2)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
sd  input  1  security-domain tag; every non-clock/reset port belongs to domain sd
imemreq_val  output  1  request valid
imemreq_rdy  input  1  memory accepts request
imemreq_addr  output  p_addr_nbits  request address (current PC)
imemresp_val  input  1  response valid; always accepted, in request order
imemresp_data  input  p_data_nbits  instruction
redirect_val  input  1  squash from downstream (aggregated prev_squash)
redirect_target  input  p_addr_nbits  new PC
next_stall  input  1  aggregated stall from downstream stage
next_val  output  1  valid to downstream (its prev_val)
next_pc  output  p_addr_nbits  PC of presented instruction
next_inst  output  p_data_nbits  presented instruction

Behaviour:
- Clock port is clk, reset port is reset. One clock; reset is synchronous and active-high.
- Reset values:
  - PC = p_reset_pc.
  - All buffer entries invalid; drop_count = 0.
  - imemreq_val = 0 and next_val = 0 during any cycle in which reset is high.
- Fetch buffer:
  - Circular FIFO of p_max_inflight entries, each {alloc, filled, pc, inst}.
  - Read and write pointers wrap modulo depth.
- Request issue:
  - Condition: imemreq_val = !reset && !redirect_val && (occupied + drop_count < p_max_inflight).
  - imemreq_addr = PC.
  - On fire (val && rdy): allocate tail entry {alloc=1, filled=0, pc=PC}; PC <= PC + 4 (wraps modulo 2^p_addr_nbits).
- Response:
  - If drop_count > 0: discard the response and decrement drop_count.
  - Otherwise: write inst into the oldest allocated-unfilled entry and set filled=1.
  - A response arriving with no pending request is illegal; assert in simulation.
- Output:
  - next_val = head.alloc && head.filled && !redirect_val.
  - next_pc and next_inst come from the head entry; they are don't-care when next_val = 0.
  - Dequeue head when next_val && !next_stall.
- Latency: request fire at cycle t, response at t+k, next_val earliest at t+k+1.
- Redirect (redirect_val = 1):
  - PC <= redirect_target.
  - No request issued that cycle; no dequeue.
  - All entries invalidated.
  - drop_count <= drop_count + unfilled_count - imemresp_val. The response arriving that cycle is discarded.
  - First request to the target is issued the following cycle.
- Simultaneous events:
  - Redirect beats request, response, and dequeue.
  - Allocate, fill, and dequeue in the same cycle are all permitted.
  - Full buffer with dequeue in the same cycle: request still blocked this cycle (credit evaluated on registered occupancy).
- Stall: entries held and no dequeue. Requests continue until credits are exhausted.
- Counter widths: drop_count and occupancy are clog2(p_max_inflight)+1 bits. Invariant: drop_count + occupied <= p_max_inflight; never overflows.
- Reset mid-operation: all state is cleared. Memory is assumed reset together with this block, so no stale responses arrive.

Optional Feature:
- Macro: PIPE_FETCH_RESP_BYPASS_EN.
- Defined:
  - When the head entry is allocated-unfilled and a non-dropped response arrives, next_val = !redirect_val and next_inst = imemresp_data in the same cycle.
  - If !next_stall, the head is dequeued without ever being written filled.
  - Latency becomes t+k.
- Undefined: registered path only, latency t+k+1.

Test Plan:
- Reset, imemreq_rdy=1, 1-cycle memory, next_stall=0 -> requests to 0x200, 0x204, 0x208…; next_val pulses with next_pc=0x200 first, at cycle 3 after reset deassert (cycle 2 with bypass).
- imemreq_rdy=0 for 5 cycles after reset -> imemreq_addr held at 0x200, PC unchanged, next_val=0 throughout.
- next_stall=1 held, memory never stalls -> exactly 2 requests (0x200, 0x204) fire, then imemreq_val=0; release stall -> 0x200 then 0x204 presented on consecutive cycles, then fetch resumes at 0x208.
- 3-cycle memory latency, 2 requests outstanding, redirect_val=1 target 0x400 -> both stale responses discarded (drop_count 2→1→0), first presented next_pc=0x400.
- Redirect in the same cycle as a response arrives, one more request outstanding -> arriving response dropped, drop_count=1, next response dropped, 0x400 presented afterward.
- Back-to-back redirects to 0x400 then 0x800 with 2 in flight -> only next_pc=0x800 ever presented; drop_count never exceeds 2.
